// File: rtl/id_operand_fwd_pkg.sv
// id_operand_fwd_pkg
//   Shared definitions for the ID-stage operand forwarding block:
//   FSM state encodings, EX forward flag codes and the flag
//   qualification helper used by the top module.
package id_operand_fwd_pkg;

   typedef enum logic [1:0] {
      FWD_IDLE     = 2'd0,
      FWD_MEM_WAIT = 2'd1,
      FWD_RELEASE  = 2'd2
   } fwd_state_e;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_LOAD = 2'b01;
   localparam logic [1:0] FWD_EX   = 2'b11;

   // The incoming flags come from an unqualified address compare, so a flag
   // only means something when ID is valid, EX really writes rd and rs!=x0.
   function automatic logic [1:0] qualify_flag(input logic [1:0] flag,
                                               input logic       id_valid,
                                               input logic       ex_we,
                                               input logic [4:0] raddr);
      return (id_valid && ex_we && (raddr != 5'd0)) ? flag : FWD_NONE;
   endfunction

endpackage

// File: rtl/id_operand_fwd_mux.sv
// fwd_operand_mux
//   Combinational per-operand priority mux.
//   Ports:
//     raddr_i      source register address
//     flag_i       qualified EX forward flag
//     cap_sel_i    select captured load data
//     cap_data_i   captured load data
//     ex_data_i    EX-stage result
//     wb_we_i      WB writes rd
//     wb_waddr_i   WB rd
//     wb_data_i    WB data
//     rf_data_i    register file data
//     operand_o    selected operand
module fwd_operand_mux
   import id_operand_fwd_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [4:0]    raddr_i,
   input  logic [1:0]    flag_i,
   input  logic          cap_sel_i,
   input  logic [DW-1:0] cap_data_i,
   input  logic [DW-1:0] ex_data_i,
   input  logic          wb_we_i,
   input  logic [4:0]    wb_waddr_i,
   input  logic [DW-1:0] wb_data_i,
   input  logic [DW-1:0] rf_data_i,
   output logic [DW-1:0] operand_o
);

   always_comb begin
      operand_o = rf_data_i;
      if (raddr_i == 5'd0) begin
         operand_o = '0;
      end else if (cap_sel_i) begin
         operand_o = cap_data_i;
      end else if (flag_i == FWD_EX) begin
         operand_o = ex_data_i;
      end else if (wb_we_i && (wb_waddr_i == raddr_i)) begin
         operand_o = wb_data_i;
      end
   end

endmodule

// File: rtl/id_operand_fwd.sv
// id_operand_fwd
//   ID-stage operand selection with EX/WB forwarding and a load-use FSM
//   that holds ID until the load data returns from MEM, captures it and
//   presents it for one RELEASE cycle.
//   Ports:
//     clk, rst                      clock, async active-low reset
//     id_valid_i                    ID holds a real instruction
//     id_reg{1,2}_raddr_i           rs1/rs2 addresses
//     reg{1,2}_rdata_i              regfile data
//     reg{1,2}_exforward_flag_i     EX forward flags (11 EX, 01 load, 00 none)
//     ex_reg_we_i/waddr_i/wdata_i   EX write-back info
//     mem_rdata_vld_i/reg_waddr_i/rdata_i  MEM load return
//     wb_reg_we_i/waddr_i/wdata_i   WB bypass
//     reg{1,2}_rdata_o              final operands
//     hold_req_o                    hold PC/IF/ID request
//     fwd_timeout_o                 one-cycle MEM wait timeout pulse
module id_operand_fwd
   import id_operand_fwd_pkg::*;
#(
   parameter int DW       = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid_i,
   input  logic [4:0]    id_reg1_raddr_i,
   input  logic [4:0]    id_reg2_raddr_i,
   input  logic [DW-1:0] reg1_rdata_i,
   input  logic [DW-1:0] reg2_rdata_i,
   input  logic [1:0]    reg1_exforward_flag_i,
   input  logic [1:0]    reg2_exforward_flag_i,
   input  logic          ex_reg_we_i,
   input  logic [4:0]    ex_reg_waddr_i,
   input  logic [DW-1:0] ex_reg_wdata_i,
   input  logic          mem_rdata_vld_i,
   input  logic [4:0]    mem_reg_waddr_i,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          wb_reg_we_i,
   input  logic [4:0]    wb_reg_waddr_i,
   input  logic [DW-1:0] wb_reg_wdata_i,
   output logic [DW-1:0] reg1_rdata_o,
   output logic [DW-1:0] reg2_rdata_o,
   output logic          hold_req_o,
   output logic          fwd_timeout_o
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   fwd_state_e    state_q, state_d;
   logic [1:0]    mask_q, mask_d;          // {r2hit, r1hit}
   logic [4:0]    ld_addr_q, ld_addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] cap1_q, cap1_d;
   logic [DW-1:0] cap2_q, cap2_d;
   logic          tmo_q, tmo_d;

   logic [1:0] qflag1, qflag2;
   logic       ld1, ld2;

   assign qflag1 = qualify_flag(reg1_exforward_flag_i, id_valid_i, ex_reg_we_i, id_reg1_raddr_i);
   assign qflag2 = qualify_flag(reg2_exforward_flag_i, id_valid_i, ex_reg_we_i, id_reg2_raddr_i);
   assign ld1    = (qflag1 == FWD_LOAD);
   assign ld2    = (qflag2 == FWD_LOAD);

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      ld_addr_d  = ld_addr_q;
      cnt_d      = cnt_q;
      cap1_d     = cap1_q;
      cap2_d     = cap2_q;
      tmo_d      = 1'b0;
      hold_req_o = 1'b0;
      unique case (state_q)
         FWD_IDLE: begin
            if (ld1 || ld2) begin
               hold_req_o = 1'b1;
               state_d    = FWD_MEM_WAIT;
               ld_addr_d  = ex_reg_waddr_i;
               // An 11 on the other operand names the same EX instruction,
               // i.e. the load itself, so it waits for the same data.
               mask_d     = {ld2 || (qflag2 == FWD_EX), ld1 || (qflag1 == FWD_EX)};
               cnt_d      = '0;
            end
         end
         FWD_MEM_WAIT: begin
            hold_req_o = 1'b1;
            if (mem_rdata_vld_i && (mem_reg_waddr_i == ld_addr_q)) begin
               if (mask_q[0]) cap1_d = mem_rdata_i;
               if (mask_q[1]) cap2_d = mem_rdata_i;
               state_d = FWD_RELEASE;
            end else if (cnt_q != MAX_CNT) begin
               cnt_d = cnt_q + 1'b1;
               tmo_d = (cnt_d == MAX_CNT);
            end
         end
         FWD_RELEASE: begin
            state_d = FWD_IDLE;
         end
         default: begin
            state_d = FWD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FWD_IDLE;
         mask_q    <= '0;
         ld_addr_q <= '0;
         cnt_q     <= '0;
         cap1_q    <= '0;
         cap2_q    <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         ld_addr_q <= ld_addr_d;
         cnt_q     <= cnt_d;
         cap1_q    <= cap1_d;
         cap2_q    <= cap2_d;
         tmo_q     <= tmo_d;
      end
   end

   assign fwd_timeout_o = tmo_q;

   fwd_operand_mux #(.DW(DW)) u_mux1 (
      .raddr_i    (id_reg1_raddr_i),
      .flag_i     (qflag1),
      .cap_sel_i  ((state_q == FWD_RELEASE) && mask_q[0]),
      .cap_data_i (cap1_q),
      .ex_data_i  (ex_reg_wdata_i),
      .wb_we_i    (wb_reg_we_i),
      .wb_waddr_i (wb_reg_waddr_i),
      .wb_data_i  (wb_reg_wdata_i),
      .rf_data_i  (reg1_rdata_i),
      .operand_o  (reg1_rdata_o)
   );

   fwd_operand_mux #(.DW(DW)) u_mux2 (
      .raddr_i    (id_reg2_raddr_i),
      .flag_i     (qflag2),
      .cap_sel_i  ((state_q == FWD_RELEASE) && mask_q[1]),
      .cap_data_i (cap2_q),
      .ex_data_i  (ex_reg_wdata_i),
      .wb_we_i    (wb_reg_we_i),
      .wb_waddr_i (wb_reg_waddr_i),
      .wb_data_i  (wb_reg_wdata_i),
      .rf_data_i  (reg2_rdata_i),
      .operand_o  (reg2_rdata_o)
   );

endmodule

// File: tb/tb_id_operand_fwd.sv
module tb_id_operand_fwd;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid_i;
   logic [4:0]    id_reg1_raddr_i, id_reg2_raddr_i;
   logic [DW-1:0] reg1_rdata_i, reg2_rdata_i;
   logic [1:0]    reg1_exforward_flag_i, reg2_exforward_flag_i;
   logic          ex_reg_we_i;
   logic [4:0]    ex_reg_waddr_i;
   logic [DW-1:0] ex_reg_wdata_i;
   logic          mem_rdata_vld_i;
   logic [4:0]    mem_reg_waddr_i;
   logic [DW-1:0] mem_rdata_i;
   logic          wb_reg_we_i;
   logic [4:0]    wb_reg_waddr_i;
   logic [DW-1:0] wb_reg_wdata_i;
   logic [DW-1:0] reg1_rdata_o, reg2_rdata_o;
   logic          hold_req_o, fwd_timeout_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_operand_fwd #(.DW(DW), .MAX_WAIT(15)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .id_valid_i            (id_valid_i),
      .id_reg1_raddr_i       (id_reg1_raddr_i),
      .id_reg2_raddr_i       (id_reg2_raddr_i),
      .reg1_rdata_i          (reg1_rdata_i),
      .reg2_rdata_i          (reg2_rdata_i),
      .reg1_exforward_flag_i (reg1_exforward_flag_i),
      .reg2_exforward_flag_i (reg2_exforward_flag_i),
      .ex_reg_we_i           (ex_reg_we_i),
      .ex_reg_waddr_i        (ex_reg_waddr_i),
      .ex_reg_wdata_i        (ex_reg_wdata_i),
      .mem_rdata_vld_i       (mem_rdata_vld_i),
      .mem_reg_waddr_i       (mem_reg_waddr_i),
      .mem_rdata_i           (mem_rdata_i),
      .wb_reg_we_i           (wb_reg_we_i),
      .wb_reg_waddr_i        (wb_reg_waddr_i),
      .wb_reg_wdata_i        (wb_reg_wdata_i),
      .reg1_rdata_o          (reg1_rdata_o),
      .reg2_rdata_o          (reg2_rdata_o),
      .hold_req_o            (hold_req_o),
      .fwd_timeout_o         (fwd_timeout_o)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic quiet();
      reg1_exforward_flag_i = 2'b00;
      reg2_exforward_flag_i = 2'b00;
      ex_reg_we_i           = 1'b0;
      mem_rdata_vld_i       = 1'b0;
      wb_reg_we_i           = 1'b0;
   endtask

   initial begin
      int tmo_cnt, tmo_idx, hold_low;

      rst             = 1'b0;
      id_valid_i      = 1'b0;
      id_reg1_raddr_i = 5'd3;
      id_reg2_raddr_i = 5'd4;
      reg1_rdata_i    = 32'h3333_3333;
      reg2_rdata_i    = 32'h4444_4444;
      ex_reg_waddr_i  = 5'd0;
      ex_reg_wdata_i  = 32'h0;
      mem_reg_waddr_i = 5'd0;
      mem_rdata_i     = 32'h0;
      wb_reg_waddr_i  = 5'd0;
      wb_reg_wdata_i  = 32'h0;
      quiet();

      // Reset state
      #2;
      check("rst_hold", {31'd0, hold_req_o}, 32'd0);
      check("rst_tmo", {31'd0, fwd_timeout_o}, 32'd0);
      check("rst_op1_rf", reg1_rdata_o, 32'h3333_3333);
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // EX forward: ADD x5 in EX
      id_valid_i = 1'b1;
      id_reg1_raddr_i = 5'd5;
      reg1_exforward_flag_i = 2'b11;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd5; ex_reg_wdata_i = 32'h1234;
      wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'd5; wb_reg_wdata_i = 32'hAAAA;
      settle();
      check("ex_fwd_op1", reg1_rdata_o, 32'h1234);
      check("ex_fwd_hold", {31'd0, hold_req_o}, 32'd0);
      check("ex_fwd_op2_rf", reg2_rdata_o, 32'h4444_4444);
      next_cycle();

      // Unqualified flag (ex_we=0) falls through to WB bypass
      ex_reg_we_i = 1'b0;
      settle();
      check("wb_fwd_op1", reg1_rdata_o, 32'hAAAA);
      id_reg1_raddr_i = 5'd0;
      settle();
      check("x0_op1", reg1_rdata_o, 32'h0);
      next_cycle();

      // id_valid low: load flag ignored
      quiet();
      id_valid_i = 1'b0;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd6;
      id_reg2_raddr_i = 5'd6; reg2_exforward_flag_i = 2'b01;
      settle();
      check("novalid_hold", {31'd0, hold_req_o}, 32'd0);
      next_cycle();

      // Load-use on rs2, valid in the first MEM_WAIT cycle
      id_valid_i = 1'b1;
      id_reg1_raddr_i = 5'd3;
      reg2_rdata_i = 32'h5555_5555;
      settle();
      check("ld2_detect_hold", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      quiet();
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd6; mem_rdata_i = 32'hDEAD_BEEF;
      settle();
      check("ld2_wait_hold", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("ld2_rel_hold", {31'd0, hold_req_o}, 32'd0);
      check("ld2_rel_op2", reg2_rdata_o, 32'hDEAD_BEEF);
      check("ld2_rel_op1_rf", reg1_rdata_o, 32'h3333_3333);
      next_cycle();
      settle();
      check("ld2_idle_op2_rf", reg2_rdata_o, 32'h5555_5555);
      check("ld2_idle_hold", {31'd0, hold_req_o}, 32'd0);
      next_cycle();

      // Both operands on the same load, valid on the 3rd MEM_WAIT cycle
      id_reg1_raddr_i = 5'd6; id_reg2_raddr_i = 5'd6;
      reg1_exforward_flag_i = 2'b01; reg2_exforward_flag_i = 2'b01;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd6;
      settle();
      check("ld12_hold_c1", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      quiet();
      settle();
      check("ld12_hold_c2", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      settle();
      check("ld12_hold_c3", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd6; mem_rdata_i = 32'hDEAD_BEEF;
      settle();
      check("ld12_hold_c4", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("ld12_rel_hold", {31'd0, hold_req_o}, 32'd0);
      check("ld12_rel_op1", reg1_rdata_o, 32'hDEAD_BEEF);
      check("ld12_rel_op2", reg2_rdata_o, 32'hDEAD_BEEF);
      next_cycle();

      // Mixed 01/11 on the same EX instruction: both wait for the load
      id_reg1_raddr_i = 5'd7; id_reg2_raddr_i = 5'd7;
      reg1_exforward_flag_i = 2'b01; reg2_exforward_flag_i = 2'b11;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd7; ex_reg_wdata_i = 32'h0BAD;
      settle();
      check("mix_hold", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      quiet();
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd7; mem_rdata_i = 32'hCAFE_F00D;
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("mix_rel_op1", reg1_rdata_o, 32'hCAFE_F00D);
      check("mix_rel_op2", reg2_rdata_o, 32'hCAFE_F00D);
      next_cycle();

      // Timeout: no valid for 20 MEM_WAIT cycles
      id_reg1_raddr_i = 5'd8; id_reg2_raddr_i = 5'd3;
      reg1_exforward_flag_i = 2'b01;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd8;
      next_cycle();
      quiet();
      tmo_cnt = 0; tmo_idx = 0; hold_low = 0;
      for (int k = 1; k <= 20; k++) begin
         settle();
         if (fwd_timeout_o) begin tmo_cnt++; tmo_idx = k; end
         if (!hold_req_o) hold_low++;
         next_cycle();
      end
      check("tmo_pulses", tmo_cnt, 32'd1);
      check("tmo_cycle", tmo_idx, 32'd16);
      check("tmo_hold_low", hold_low, 32'd0);
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd7; mem_rdata_i = 32'h7777;
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("wrong_rd_hold", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd8; mem_rdata_i = 32'h8888_0001;
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("tmo_rel_hold", {31'd0, hold_req_o}, 32'd0);
      check("tmo_rel_op1", reg1_rdata_o, 32'h8888_0001);
      next_cycle();

      // Async reset during MEM_WAIT
      id_reg1_raddr_i = 5'd3; id_reg2_raddr_i = 5'd9;
      reg2_exforward_flag_i = 2'b01;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd9;
      next_cycle();
      quiet();
      settle();
      check("rstw_pre_hold", {31'd0, hold_req_o}, 32'd1);
      rst = 1'b0;
      #1;
      check("rstw_hold", {31'd0, hold_req_o}, 32'd0);
      check("rstw_tmo", {31'd0, fwd_timeout_o}, 32'd0);
      check("rstw_op2_rf", reg2_rdata_o, 32'h5555_5555);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      settle();
      check("rstw_idle_hold", {31'd0, hold_req_o}, 32'd0);
      next_cycle();

      // Fresh load-use after reset
      id_reg1_raddr_i = 5'd10;
      reg1_exforward_flag_i = 2'b01;
      ex_reg_we_i = 1'b1; ex_reg_waddr_i = 5'd10;
      settle();
      check("post_hold", {31'd0, hold_req_o}, 32'd1);
      next_cycle();
      quiet();
      mem_rdata_vld_i = 1'b1; mem_reg_waddr_i = 5'd10; mem_rdata_i = 32'h1010_1010;
      next_cycle();
      mem_rdata_vld_i = 1'b0;
      settle();
      check("post_rel_op1", reg1_rdata_o, 32'h1010_1010);
      check("post_rel_op2_rf", reg2_rdata_o, 32'h5555_5555);
      check("post_rel_hold", {31'd0, hold_req_o}, 32'd0);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
